// File: rtl/bmult_acc_stage_if.sv
// rtl/bmult_acc_stage_if.sv - product stream in, dot-product result out, for bmult_acc_stage
interface bmult_acc_stage_if #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
);
  logic             p_valid;
  logic             p_last;
  logic [23:0]      P;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output p_valid, p_last, P, flush, out_ready,
    input  out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  p_valid, p_last, P, flush, out_ready,
    output out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/bmult_acc_stage.sv
// rtl/bmult_acc_stage.sv - per-vector accumulator with one-entry result register; BMULT_ACC_SAT_EN selects clamping on overflow
module bmult_acc_stage #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  bmult_acc_stage_if.slave bus,
  output logic             overrun
);
  localparam logic [0:0]       S_IDLE  = 1'b0;
  localparam logic [0:0]       S_ACCUM = 1'b1;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] hold_sum;
  logic [LEN_W-1:0] hold_count;
  logic             hold_ovf;
  logic             hold_valid;

  logic             beat;
  logic             done;
  logic             pop;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_ext;
  logic             ovf_next;
  logic [ACC_W-1:0] sum_next;
  logic [LEN_W-1:0] cnt_next;

  // Next accumulator/count/overflow values for a beat arriving this cycle
  always_comb begin
    beat     = bus.p_valid & ~bus.flush;
    done     = beat & bus.p_last;
    pop      = hold_valid & bus.out_ready;
    base     = (state == S_IDLE) ? '0 : acc;
    sum_ext  = {1'b0, base} + {{(ACC_W + 1 - 24){1'b0}}, bus.P};
    ovf_next = ((state == S_ACCUM) & ovf) | sum_ext[ACC_W];
`ifdef BMULT_ACC_SAT_EN
    // Once the vector has overflowed, the sum is pinned at all-ones
    sum_next = ovf_next ? '1 : sum_ext[ACC_W-1:0];
`else
    sum_next = sum_ext[ACC_W-1:0];
`endif
    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end

  // Accumulator FSM: flush beats any coincident beat; a last beat returns to IDLE
  always_ff @(posedge clk) begin
    if (rst || bus.flush || done) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (beat) begin
      state <= S_ACCUM;
      acc   <= sum_next;
      cnt   <= cnt_next;
      ovf   <= ovf_next;
    end
  end

  // Holding register: load on completion when empty or popping, else drop and flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_sum   <= '0;
      hold_count <= '0;
      hold_ovf   <= 1'b0;
      overrun    <= 1'b0;
    end else if (done && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_sum   <= sum_next;
      hold_count <= cnt_next;
      hold_ovf   <= ovf_next;
    end else if (done) begin
      overrun    <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign bus.out_valid = hold_valid;
  assign bus.out_sum   = hold_sum;
  assign bus.out_count = hold_count;
  assign bus.out_ovf   = hold_ovf;
endmodule

// File: tb/tb_bmult_acc_stage.sv
// tb/tb_bmult_acc_stage.sv - directed self-checking bench for bmult_acc_stage
module tb_bmult_acc_stage;
  logic clk = 1'b0;
  logic rst;
  logic ov_a;
  logic ov_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bmult_acc_stage_if #(.ACC_W(32), .LEN_W(8)) ia ();
  bmult_acc_stage_if #(.ACC_W(24), .LEN_W(8)) ib ();

  bmult_acc_stage #(.ACC_W(32), .LEN_W(8)) u_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (ia),
    .overrun (ov_a)
  );

  bmult_acc_stage #(.ACC_W(24), .LEN_W(8)) u_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (ib),
    .overrun (ov_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic l, input logic [23:0] p, input logic f);
    ia.p_valid = v;
    ia.p_last  = l;
    ia.P       = p;
    ia.flush   = f;
    step();
  endtask

  task automatic check_a(input string tag, input logic v, input logic [31:0] s,
                         input logic [7:0] c, input logic o);
    check({tag, "_valid"}, 64'(ia.out_valid), 64'(v));
    check({tag, "_sum"},   64'(ia.out_sum),   64'(s));
    check({tag, "_count"}, 64'(ia.out_count), 64'(c));
    check({tag, "_ovf"},   64'(ia.out_ovf),   64'(o));
  endtask

  initial begin
    rst = 1'b1;
    ia.p_valid = 1'b0; ia.p_last = 1'b0; ia.P = '0; ia.flush = 1'b0; ia.out_ready = 1'b1;
    ib.p_valid = 1'b0; ib.p_last = 1'b0; ib.P = '0; ib.flush = 1'b0; ib.out_ready = 1'b1;
    step();
    step();
    check_a("reset", 1'b0, 32'd0, 8'd0, 1'b0);
    check("reset_overrun", 64'(ov_a), 64'd0);
    rst = 1'b0;

    // 1 + 2 + 3
    drive_a(1'b1, 1'b0, 24'h000001, 1'b0);
    drive_a(1'b1, 1'b0, 24'h000002, 1'b0);
    drive_a(1'b1, 1'b1, 24'h000003, 1'b0);
    check_a("sum3", 1'b1, 32'd6, 8'd3, 1'b0);

    // single-beat vector, then a back-to-back second vector
    drive_a(1'b1, 1'b1, 24'hFFFFFF, 1'b0);
    check_a("single", 1'b1, 32'h00FFFFFF, 8'd1, 1'b0);
    drive_a(1'b1, 1'b0, 24'h000010, 1'b0);
    drive_a(1'b1, 1'b1, 24'h000020, 1'b0);
    check_a("b2b", 1'b1, 32'h30, 8'd2, 1'b0);
    drive_a(1'b0, 1'b0, 24'h0, 1'b0);
    check_a("popped", 1'b0, 32'h30, 8'd2, 1'b0);

    // 24-bit accumulator overflow
    ib.p_valid = 1'b1; ib.p_last = 1'b0; ib.P = 24'hFFFFFF;
    step();
    ib.p_last = 1'b1; ib.P = 24'h000002;
    step();
    ib.p_valid = 1'b0; ib.p_last = 1'b0;
`ifdef BMULT_ACC_SAT_EN
    check("w24_sum", 64'(ib.out_sum), 64'h00FFFFFF);
`else
    check("w24_sum", 64'(ib.out_sum), 64'h000001);
`endif
    check("w24_ovf",   64'(ib.out_ovf),   64'd1);
    check("w24_count", 64'(ib.out_count), 64'd2);
    check("w24_valid", 64'(ib.out_valid), 64'd1);

    // 300 beats of 0xFFFFFF: count saturates, 32-bit sum overflows
    for (int i = 0; i < 299; i++) drive_a(1'b1, 1'b0, 24'hFFFFFF, 1'b0);
    drive_a(1'b1, 1'b1, 24'hFFFFFF, 1'b0);
`ifdef BMULT_ACC_SAT_EN
    check_a("long", 1'b1, 32'hFFFFFFFF, 8'd255, 1'b1);
`else
    check_a("long", 1'b1, 32'd738197204, 8'd255, 1'b1);
`endif
    drive_a(1'b0, 1'b0, 24'h0, 1'b0);

    // back-pressure: 5 held, 7 dropped
    ia.out_ready = 1'b0;
    drive_a(1'b1, 1'b0, 24'd2, 1'b0);
    drive_a(1'b1, 1'b1, 24'd3, 1'b0);
    check_a("hold5", 1'b1, 32'd5, 8'd2, 1'b0);
    check("no_overrun_yet", 64'(ov_a), 64'd0);
    drive_a(1'b1, 1'b1, 24'd7, 1'b0);
    check_a("drop7", 1'b1, 32'd5, 8'd2, 1'b0);
    check("overrun_set", 64'(ov_a), 64'd1);
    // pop in the same cycle that 9 completes
    drive_a(1'b1, 1'b0, 24'd4, 1'b0);
    ia.out_ready = 1'b1;
    drive_a(1'b1, 1'b1, 24'd5, 1'b0);
    check_a("pop_load9", 1'b1, 32'd9, 8'd2, 1'b0);
    check("overrun_sticky", 64'(ov_a), 64'd1);

    // flush discards 3, 4 and the coincident 8
    drive_a(1'b1, 1'b0, 24'd3, 1'b0);
    drive_a(1'b1, 1'b0, 24'd4, 1'b0);
    drive_a(1'b1, 1'b0, 24'd8, 1'b1);
    check("flush_no_completion", 64'(ia.out_valid), 64'd0);
    drive_a(1'b1, 1'b1, 24'd2, 1'b0);
    check_a("flush", 1'b1, 32'd2, 8'd1, 1'b0);

    // reset mid-vector with the register full and overrun set
    ia.out_ready = 1'b0;
    drive_a(1'b1, 1'b0, 24'd5, 1'b0);
    rst = 1'b1;
    drive_a(1'b1, 1'b0, 24'd6, 1'b0);
    check_a("midrst", 1'b0, 32'd0, 8'd0, 1'b0);
    check("midrst_overrun", 64'(ov_a), 64'd0);
    rst = 1'b0;
    drive_a(1'b1, 1'b1, 24'h10, 1'b0);
    check_a("after_rst", 1'b1, 32'h10, 8'd1, 1'b0);
    drive_a(1'b0, 1'b0, 24'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bmult_acc_stage.md
# bmult_acc_stage

Downstream accumulation stage for the 12x12 bit-heap multiplier. It takes the 24-bit product stream `P` with an aligned valid/last tag and sums the products of one vector into a wide accumulator. It presents each completed dot-product in a one-entry holding register with a valid/ready handshake. The multiplier cannot stall, so the block never back-pressures its input; it flags results it cannot store instead.

## Interface
- `ACC_W`, default 32: accumulator and result width; must be ≥ 24.
- `LEN_W`, default 8: width of the beat counter and `out_count`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `p_valid`  in  1: `P` carries a product this cycle.
- `p_last`  in  1: final beat of the current vector; ignored unless `p_valid`.
- `P`  in  24: unsigned product from the multiplier, aligned with `p_valid`.
- `flush`  in  1: abort the partial accumulation.
- `out_valid`  out  1: holding register is full.
- `out_ready`  in  1: consumer accepts the result.
- `out_sum`  out  `ACC_W`: completed vector sum.
- `out_count`  out  `LEN_W`: beats in the vector; saturates at all-ones.
- `out_ovf`  out  1: the sum overflowed `ACC_W` during this vector.
- `overrun`  out  1: sticky flag; a completed result was dropped.

## Operation
- Accumulator FSM has two states.
  - IDLE: `cnt`=0, accumulator empty.
  - ACCUM: at least one beat has been absorbed.
- Beat (`p_valid` & !`flush`):
  - next sum = (IDLE ? 0 : `acc`) + zero-extended `P`;
  - `cnt` increments and saturates at 2^`LEN_W`−1;
  - the overflow bit is ORed with the carry-out of `ACC_W`.
- A beat without `p_last` moves the FSM to ACCUM.
- A beat with `p_last` produces a completion:
  - the completion carries next sum, `cnt`+1 (saturated) and the overflow bit;
  - the FSM returns to IDLE and `acc`, `cnt` and the overflow bit clear.
- A single-beat vector (`p_last` in IDLE) is legal and has `out_count`=1.
- `flush`: the FSM goes to IDLE and clears `acc`, `cnt` and the overflow bit.
  - `flush` takes priority over a coincident beat, which is discarded. No completion occurs.
- Holding register: empty or FULL (`out_valid`=1).
  - Pop: `out_valid` & `out_ready`.
  - Completion while empty, or in the same cycle as a pop: load the register; `out_valid`=1.
  - Completion while FULL and no pop: drop the result, set `overrun`, leave the register unchanged.
  - Pop with no completion: `out_valid`→0; `out_sum`, `out_count` and `out_ovf` keep their last values.
- `overrun` clears only on `rst`.
- Arithmetic is unsigned. Without saturation the accumulator wraps modulo 2^`ACC_W`.

## Timing
- Latency from a `p_valid`&`p_last` cycle to `out_valid`=1 is 1 cycle when the holding register can accept the result.
- Input throughput is one beat per cycle, back-to-back vectors included. A `p_last` beat can be followed immediately by the first beat of the next vector.
- `out_sum`, `out_count`, `out_ovf` and `out_valid` are driven directly from registers; there is no combinational path from any input.
- `out_ready` never affects beat acceptance.
- `rst` takes effect at the next edge and overrides every other input, including mid-vector and while the holding register is FULL.
- Reset values are zero for all outputs, the FSM (IDLE), `acc`, `cnt` and the overflow bit.

## Configuration
- `BMULT_ACC_SAT_EN` defined: on carry-out, the accumulator clamps to all-ones and stays there for the rest of the vector; `out_ovf`=1.
- `BMULT_ACC_SAT_EN` undefined: the accumulator wraps; `out_ovf` still reports that the vector overflowed.

## Test plan
- `ACC_W`=32, `out_ready`=1:
  - stimulus: beats P=0x000001, 0x000002, 0x000003 (last);
  - response, next cycle: `out_valid`=1, `out_sum`=6, `out_count`=3, `out_ovf`=0.
- Single beat P=0xFFFFFF (last):
  - response: `out_sum`=0x00FFFFFF, `out_count`=1.
  - A second vector starting the next cycle is summed independently.
- `ACC_W`=24:
  - stimulus: beats 0xFFFFFF, 0x000002 (last);
  - response without the macro: `out_sum`=0x000001, `out_ovf`=1;
  - response with `BMULT_ACC_SAT_EN`: `out_sum`=0xFFFFFF, `out_ovf`=1.
- `out_ready`=0:
  - stimulus: vector sum 5 completes, then vector sum 7 completes;
  - response: `out_sum` stays 5, `overrun`=1;
  - stimulus: raise `out_ready` in the same cycle that vector sum 9 completes;
  - response: `out_sum`=9 next cycle and `out_valid` stays 1.
- Stimulus: beats 3, 4, then `flush` together with beat 8, then beat 2 (last).
  - response: `out_sum`=2, `out_count`=1.
- Assert `rst` mid-vector while `out_valid`=1 and `overrun`=1:
  - response, next cycle: all outputs are 0;
  - a following single beat P=0x10 (last) yields `out_sum`=0x10.
